// File: rtl/wb_wport_arbiter_pkg.sv
// Shared configuration for the regfile write-port arbiter: default widths,
// buffer depth, starvation limit and the grant encoding.
package wb_wport_arbiter_pkg;

    localparam int CFG_DATA_WIDTH     = 32;
    localparam int CFG_REG_ADDR_WIDTH = 5;
    localparam int WPORT_FIFO_DEPTH   = 2;
    localparam int WPORT_STARVE_LIMIT = 4;

    // Which source owns the regfile write port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_FIFO = 2'd2
    } wport_gnt_e;

endpackage

// File: rtl/wport_rsp_fifo.sv
// Small synchronous FIFO holding {rd, data} MDU results.
// Pointers wrap naturally because the depth is a power of two.
// The caller never pushes when full or pops when empty.
module wport_rsp_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage, wrap-around pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/wb_wport_arbiter.sv
// Regfile write-port arbiter: the in-order writeback stage always wins, MDU
// results wait in a small FIFO and commit on idle WB cycles. A busy
// scoreboard tracks outstanding MDU destinations, and a starvation counter
// requests a one-cycle pipeline stall so a buffered result cannot wait forever.
module wb_wport_arbiter
    import wb_wport_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH     = CFG_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = CFG_REG_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = WPORT_FIFO_DEPTH,
    parameter int STARVE_LIMIT   = WPORT_STARVE_LIMIT,
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_reg_wen,
    input  logic [REG_ADDR_WIDTH-1:0] wb_reg_waddr,
    input  logic [DATA_WIDTH-1:0]     wb_reg_wdata,
    input  logic                      mdu_issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] mdu_issue_rd,
    input  logic                      mdu_rsp_valid,
    output logic                      mdu_rsp_ready,
    input  logic [REG_ADDR_WIDTH-1:0] mdu_rsp_rd,
    input  logic [DATA_WIDTH-1:0]     mdu_rsp_data,
    output logic                      rf_wen,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic [31:0]               busy_vec,
    output logic                      stall_req,
    output logic [CNT_W-1:0]          fifo_count
);

    localparam int ENT_W    = REG_ADDR_WIDTH + DATA_WIDTH;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0]       STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0]          DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [REG_ADDR_WIDTH-1:0] X0          = {REG_ADDR_WIDTH{1'b0}};

    logic                      wb_act_s;
    logic                      fifo_empty_s;
    logic                      push_s;
    logic                      pop_s;
    logic [ENT_W-1:0]          head_s;
    logic [REG_ADDR_WIDTH-1:0] head_rd_s;
    logic [DATA_WIDTH-1:0]     head_data_s;
    wport_gnt_e                gnt_s;

    logic [31:0]               busy_q, busy_d;
    logic [STARVE_W-1:0]       starve_q, starve_d;
    logic                      stall_q, stall_d;

    // Writes to x0 are architecturally void and must not claim the port.
    assign wb_act_s      = wb_reg_wen && (wb_reg_waddr != X0);
    // Readiness depends on occupancy only, never on a same-cycle pop.
    assign mdu_rsp_ready = (fifo_count < DEPTH_C);
    // rd = 0 responses complete the handshake but are dropped.
    assign push_s        = mdu_rsp_valid && mdu_rsp_ready && (mdu_rsp_rd != X0);
    assign {head_rd_s, head_data_s} = head_s;
    assign pop_s         = (gnt_s == GNT_FIFO);

    wport_rsp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ({mdu_rsp_rd, mdu_rsp_data}),
        .rdata_o (head_s),
        .count_o (fifo_count),
        .empty_o (fifo_empty_s)
    );

    // Fixed priority: WB first, then the buffered FIFO head.
    always_comb begin
        gnt_s = GNT_NONE;
        if (wb_act_s) begin
            gnt_s = GNT_WB;
        end else if (!fifo_empty_s) begin
            gnt_s = GNT_FIFO;
        end else begin
            gnt_s = GNT_NONE;
        end
    end

    // Write-port mux; address/data follow WB when nobody is granted.
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = wb_reg_waddr;
        rf_wdata = wb_reg_wdata;
        case (gnt_s)
            GNT_WB: begin
                rf_wen = 1'b1;
            end
            GNT_FIFO: begin
                rf_wen   = 1'b1;
                rf_waddr = head_rd_s;
                rf_wdata = head_data_s;
            end
            default: begin
                rf_wen = 1'b0;
            end
        endcase
    end

    // Scoreboard next state: clear on commit, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q;
        if (pop_s) begin
            busy_d[head_rd_s] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (mdu_issue_valid && (mdu_issue_rd != X0)) begin
            busy_d[mdu_issue_rd] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Count cycles the buffered head loses to WB; at the limit request a stall.
    always_comb begin
        stall_d  = 1'b0;
        starve_d = starve_q;
        if (!fifo_empty_s && (gnt_s == GNT_WB)) begin
            if (starve_q == STARVE_LAST) begin
                stall_d  = 1'b1;
                starve_d = {STARVE_W{1'b0}};
            end else begin
                starve_d = starve_q + STARVE_W'(1);
            end
        end else begin
            starve_d = {STARVE_W{1'b0}};
        end
    end

    // Registered scoreboard, starvation counter and stall request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= 32'd0;
            starve_q <= {STARVE_W{1'b0}};
            stall_q  <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign busy_vec  = busy_q;
    assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_wport_arbiter.sv
// Self-checking bench for wb_wport_arbiter: directed scenarios with literal
// expectations plus a randomized phase, all compared each cycle against a
// queue-based model of the write-port rules.
module tb_wb_wport_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wb_reg_wen = 1'b0;
    logic [AW-1:0] wb_reg_waddr = '0;
    logic [DW-1:0] wb_reg_wdata = '0;
    logic          mdu_issue_valid = 1'b0;
    logic [AW-1:0] mdu_issue_rd = '0;
    logic          mdu_rsp_valid = 1'b0;
    logic          mdu_rsp_ready;
    logic [AW-1:0] mdu_rsp_rd = '0;
    logic [DW-1:0] mdu_rsp_data = '0;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   busy_vec;
    logic          stall_req;
    logic [1:0]    fifo_count;

    always #5 clk = ~clk;

    wb_wport_arbiter #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (AW),
        .FIFO_DEPTH     (DEPTH),
        .STARVE_LIMIT   (LIMIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .wb_reg_wen      (wb_reg_wen),
        .wb_reg_waddr    (wb_reg_waddr),
        .wb_reg_wdata    (wb_reg_wdata),
        .mdu_issue_valid (mdu_issue_valid),
        .mdu_issue_rd    (mdu_issue_rd),
        .mdu_rsp_valid   (mdu_rsp_valid),
        .mdu_rsp_ready   (mdu_rsp_ready),
        .mdu_rsp_rd      (mdu_rsp_rd),
        .mdu_rsp_data    (mdu_rsp_data),
        .rf_wen          (rf_wen),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .busy_vec        (busy_vec),
        .stall_req       (stall_req),
        .fifo_count      (fifo_count)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: buffered results in arrival order, outstanding registers,
    // how many cycles in a row the head has lost to WB, and the pending stall.
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;
    ent_t        m_q[$];
    bit   [31:0] m_busy;
    int          m_blocked;
    bit          m_stall;
    logic [AW-1:0] iss_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy    = 32'd0;
        m_blocked = 0;
        m_stall   = 1'b0;
        iss_q.delete();
    endtask

    // Outputs the model demands for the current inputs.
    task automatic compare_model();
        bit wb_act;
        wb_act = wb_reg_wen && (wb_reg_waddr != 5'd0);
        chk("m_count", fifo_count, m_q.size());
        chk("m_ready", mdu_rsp_ready, (m_q.size() < DEPTH) ? 1 : 0);
        chk("m_busy", busy_vec, m_busy);
        chk("m_stall", stall_req, m_stall);
        if (wb_act) begin
            chk("m_wen_wb", rf_wen, 1);
            chk("m_addr_wb", rf_waddr, wb_reg_waddr);
            chk("m_data_wb", rf_wdata, wb_reg_wdata);
        end else if (m_q.size() > 0) begin
            chk("m_wen_fifo", rf_wen, 1);
            chk("m_addr_fifo", rf_waddr, m_q[0].rd);
            chk("m_data_fifo", rf_wdata, m_q[0].data);
        end else begin
            chk("m_wen_idle", rf_wen, 0);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        bit wb_act, had_head, ready;
        bit next_stall;
        wb_act   = wb_reg_wen && (wb_reg_waddr != 5'd0);
        had_head = (m_q.size() > 0);
        ready    = (m_q.size() < DEPTH);
        if (!wb_act && had_head) begin
            m_busy[m_q[0].rd] = 1'b0;
            void'(m_q.pop_front());
        end
        if (mdu_rsp_valid && ready && mdu_rsp_rd != 5'd0) begin
            m_q.push_back({mdu_rsp_rd, mdu_rsp_data});
        end
        if (mdu_issue_valid && mdu_issue_rd != 5'd0) begin
            m_busy[mdu_issue_rd] = 1'b1;
        end
        next_stall = 1'b0;
        if (had_head && wb_act) begin
            m_blocked++;
            if (m_blocked == LIMIT) begin
                next_stall = 1'b1;
                m_blocked  = 0;
            end
        end else begin
            m_blocked = 0;
        end
        m_stall = next_stall;
    endtask

    task automatic drive(input bit wen, input int waddr, input int wdata,
                         input bit iv, input int ird,
                         input bit rv, input int rrd, input int rdata);
        @(negedge clk);
        wb_reg_wen      = wen;
        wb_reg_waddr    = AW'(waddr);
        wb_reg_wdata    = DW'(wdata);
        mdu_issue_valid = iv;
        mdu_issue_rd    = AW'(ird);
        mdu_rsp_valid   = rv;
        mdu_rsp_rd      = AW'(rrd);
        mdu_rsp_data    = DW'(rdata);
        #1;
        compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_update();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        // Reset: rf_* follows WB combinationally, everything else cleared.
        @(negedge clk);
        wb_reg_wen = 1'b1; wb_reg_waddr = 5'd3; wb_reg_wdata = 32'hABCD;
        #1;
        chk("rst_wen", rf_wen, 1);
        chk("rst_waddr", rf_waddr, 3);
        chk("rst_wdata", rf_wdata, 32'hABCD);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", mdu_rsp_ready, 1);
        chk("rst_busy", busy_vec, 0);
        chk("rst_stall", stall_req, 0);
        @(negedge clk);
        wb_reg_wen = 1'b0; wb_reg_waddr = '0; wb_reg_wdata = '0;
        rst = 1'b1;

        // WB write passes straight through.
        drive(1, 5, 32'h1234, 0, 0, 0, 0, 0);
        chk("wb_wen", rf_wen, 1);
        chk("wb_waddr", rf_waddr, 5);
        chk("wb_wdata", rf_wdata, 32'h1234);
        chk("wb_count", fifo_count, 0);
        tick();

        // Issue x7, response 3 cycles later, commit, busy clear.
        drive(0, 0, 0, 1, 7, 0, 0, 0); tick();
        idle(); chk("busy7_set", busy_vec[7], 1); tick();
        idle(); tick();
        drive(0, 0, 0, 0, 0, 1, 7, 32'hDEAD);
        chk("nobypass", rf_wen, 0); tick();
        idle();
        chk("x7_wen", rf_wen, 1);
        chk("x7_addr", rf_waddr, 7);
        chk("x7_data", rf_wdata, 32'hDEAD);
        chk("busy7_hold", busy_vec[7], 1); tick();
        idle(); chk("busy7_clr", busy_vec[7], 0); tick();

        // Fill the FIFO under WB traffic, see backpressure and ordering.
        drive(0, 0, 0, 1, 8, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 9, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 13, 0, 0, 0); tick();
        drive(1, 1, 32'h11, 0, 0, 1, 8, 32'h88); tick();
        drive(1, 1, 32'h22, 0, 0, 1, 9, 32'h99);
        chk("fill_cnt1", fifo_count, 1); tick();
        drive(1, 1, 32'h33, 0, 0, 1, 13, 32'hD3);
        chk("full_ready", mdu_rsp_ready, 0);
        chk("full_cnt", fifo_count, 2); tick();
        drive(0, 0, 0, 0, 0, 1, 13, 32'hD3);
        chk("full_ready2", mdu_rsp_ready, 0);
        chk("first_x8", rf_waddr, 8);
        chk("first_x8d", rf_wdata, 32'h88); tick();
        drive(0, 0, 0, 0, 0, 1, 13, 32'hD3);
        chk("pp_ready", mdu_rsp_ready, 1);
        chk("second_x9", rf_waddr, 9); tick();
        idle();
        chk("pp_cnt", fifo_count, 1);
        chk("third_x13", rf_waddr, 13); tick();
        idle(); chk("drain_cnt", fifo_count, 0); tick();

        // Starvation: x10 buffered, WB wins 4 cycles, stall pulse, commit.
        drive(0, 0, 0, 1, 10, 0, 0, 0); tick();
        drive(1, 2, 32'h2, 0, 0, 1, 10, 32'hA10); tick();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 2, i, 0, 0, 0, 0, 0);
            chk("starve_nostall", stall_req, 0); tick();
        end
        idle();
        chk("stall_hi", stall_req, 1);
        chk("stall_wen", rf_wen, 1);
        chk("stall_addr", rf_waddr, 10);
        chk("stall_data", rf_wdata, 32'hA10); tick();
        drive(1, 2, 32'h7, 0, 0, 0, 0, 0);
        chk("stall_lo", stall_req, 0);
        chk("stall_cnt", fifo_count, 0); tick();

        // WB to x0 yields to the FIFO head; rd=0 response is dropped.
        drive(0, 0, 0, 1, 11, 0, 0, 0); tick();
        drive(1, 3, 32'h3, 0, 0, 1, 11, 32'hB11); tick();
        drive(1, 0, 32'hFFFF, 0, 0, 1, 0, 32'h5);
        chk("x0_addr", rf_waddr, 11);
        chk("x0_data", rf_wdata, 32'hB11);
        chk("rd0_ready", mdu_rsp_ready, 1); tick();
        idle();
        chk("rd0_cnt", fifo_count, 0);
        chk("rd0_wen", rf_wen, 0); tick();

        // Same-cycle issue and commit on x12: set wins.
        drive(0, 0, 0, 1, 12, 0, 0, 0); tick();
        drive(1, 4, 32'h4, 0, 0, 1, 12, 32'hC12); tick();
        drive(0, 0, 0, 1, 12, 0, 0, 0);
        chk("x12_commit", rf_waddr, 12); tick();
        idle(); chk("x12_setwins", busy_vec[12], 1); tick();
        drive(0, 0, 0, 0, 0, 1, 12, 32'hC13); tick();
        idle(); tick();
        idle(); chk("x12_done", busy_vec[12], 0); tick();

        // Asynchronous reset while the FIFO is full.
        drive(0, 0, 0, 1, 14, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 15, 0, 0, 0); tick();
        drive(1, 5, 32'h55, 0, 0, 1, 14, 32'hE14); tick();
        drive(1, 5, 32'h56, 0, 0, 1, 15, 32'hE15); tick();
        drive(1, 5, 32'h57, 0, 0, 0, 0, 0);
        chk("pre_rst_cnt", fifo_count, 2);
        rst = 1'b0;
        #1;
        chk("arst_cnt", fifo_count, 0);
        chk("arst_ready", mdu_rsp_ready, 1);
        chk("arst_busy", busy_vec, 0);
        chk("arst_stall", stall_req, 0);
        chk("arst_addr", rf_waddr, 5);
        model_reset();
        tick();
        @(negedge clk);
        wb_reg_wen = 1'b0; mdu_rsp_valid = 1'b0; mdu_issue_valid = 1'b0;
        rst = 1'b1;

        // Randomized traffic obeying the upstream hazard guarantees.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit wen, iv, rv;
            int waddr, ird, rrd, idx;
            iv = 0; ird = 0; rv = 0; rrd = 0; wen = 0; waddr = 0;
            if ($urandom_range(0, 3) == 0) begin
                ird = $urandom_range(1, 31);
                if (!m_busy[ird]) iv = 1;
                else ird = 0;
            end
            if (iss_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, iss_q.size() - 1);
                rv  = 1;
                rrd = iss_q[idx];
                if (m_q.size() < DEPTH) iss_q.delete(idx);
            end else if ($urandom_range(0, 15) == 0) begin
                rv = 1;
                rrd = 0;
            end
            if (!m_stall && $urandom_range(0, 1) == 1) begin
                waddr = $urandom_range(0, 31);
                wen   = 1;
                if (waddr != 0 && (m_busy[waddr] || (iv && ird == waddr))) wen = 0;
            end
            drive(wen, waddr, $urandom, iv, ird, rv, rrd, $urandom);
            if (iv) iss_q.push_back(AW'(ird));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
